// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forward-select
// encoding, shadow writeback record and the forwarding priority helper.
package pipe_hazard_pkg;

    localparam int RA_MAX = 8;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_HOLD  = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic              v;
        logic              we;
        logic              ld;
        logic [RA_MAX-1:0] rd;
    } shadow_stage_t;

    // Youngest in-flight producer wins.
    function automatic fwd_sel_t pick_source(input logic in_ex, input logic in_mem,
                                             input logic in_wb);
        if (in_ex) begin
            return FWD_EXMEM;
        end else if (in_mem) begin
            return FWD_MEMWB;
        end else if (in_wb) begin
            return FWD_HOLD;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source operand against one shadow writeback stage, split by
// whether the producer is a load or an ALU result.
module hazard_match
    import pipe_hazard_pkg::*;
#(
    parameter int RA       = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  shadow_stage_t   stage,
    input  logic [RA-1:0]   src_addr,
    input  logic            src_used,
    output logic            hit_alu,
    output logic            hit_ld
);

    logic [RA_MAX-1:0] src_wide;
    logic              zero_dest;
    logic              hit;

    always_comb begin
        src_wide  = RA_MAX'(src_addr);
        zero_dest = ZERO_REG && (stage.rd == '0);
        hit       = stage.v && stage.we && src_used && (stage.rd == src_wide) && !zero_dest;
        hit_alu   = hit && !stage.ld;
        hit_ld    = hit && stage.ld;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks in-flight
// writebacks, raises stall/flush controls and forwards operands into EXE.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int ARQ      = 16,
    parameter int RA       = 3,
    parameter int NSRC     = 3,
    parameter bit FWD_EN   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*RA-1:0]   id_src_addr,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic                 id_wb_en,
    input  logic [RA-1:0]        id_wb_dest,
    input  logic                 id_is_load,
    input  logic                 branch_taken,
    input  logic [ARQ-1:0]       wb_data,
    input  logic [NSRC*ARQ-1:0]  ex_operand_raw,
    input  logic [ARQ-1:0]       exmem_result,
    input  logic [ARQ-1:0]       memwb_result,
    output logic                 pc_hold,
    output logic                 ifid_hold,
    output logic                 idexe_bubble,
    output logic                 ifid_flush,
    output logic                 idexe_flush,
    output logic [NSRC*ARQ-1:0]  ex_operand,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    shadow_stage_t    s_ex_q, s_ex_d;
    shadow_stage_t    s_mem_q, s_mem_d;
    shadow_stage_t    s_wb_q, s_wb_d;
    logic             hv_q, hv_d;
    logic [RA-1:0]    hrd_q, hrd_d;
    logic [ARQ-1:0]   hdata_q, hdata_d;
    fwd_sel_t         fsel_q [NSRC];
    fwd_sel_t         fsel_d [NSRC];
    logic [RA-1:0]    ex_src_q [NSRC];
    logic [RA-1:0]    ex_src_d [NSRC];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [NSRC-1:0]  alu_ex, ld_ex, alu_mem, ld_mem, alu_wb, ld_wb;
    logic [NSRC-1:0]  hit_mem, hit_wb;
    logic             stall, hold, advance;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hazard_match #(.RA(RA), .ZERO_REG(ZERO_REG)) u_ex (
            .stage    (s_ex_q),
            .src_addr (id_src_addr[i*RA +: RA]),
            .src_used (id_src_used[i]),
            .hit_alu  (alu_ex[i]),
            .hit_ld   (ld_ex[i])
        );
        hazard_match #(.RA(RA), .ZERO_REG(ZERO_REG)) u_mem (
            .stage    (s_mem_q),
            .src_addr (id_src_addr[i*RA +: RA]),
            .src_used (id_src_used[i]),
            .hit_alu  (alu_mem[i]),
            .hit_ld   (ld_mem[i])
        );
        hazard_match #(.RA(RA), .ZERO_REG(ZERO_REG)) u_wb (
            .stage    (s_wb_q),
            .src_addr (id_src_addr[i*RA +: RA]),
            .src_used (id_src_used[i]),
            .hit_alu  (alu_wb[i]),
            .hit_ld   (ld_wb[i])
        );
    end

    // With forwarding only a load still in EXE forces a wait; without it any
    // pending writer of a source interlocks until it has left WB.
    always_comb begin
        hit_mem = alu_mem | ld_mem;
        hit_wb  = alu_wb | ld_wb;
        if (FWD_EN) begin
            stall = id_valid && (|ld_ex);
        end else begin
            stall = id_valid && (|{alu_ex, ld_ex, hit_mem, hit_wb});
        end
        hold    = stall && !branch_taken;
        advance = id_valid && !stall && !branch_taken;
    end

    always_comb begin
        s_ex_d = '0;
        if (advance) begin
            s_ex_d.v  = 1'b1;
            s_ex_d.we = id_wb_en;
            s_ex_d.ld = id_is_load;
            s_ex_d.rd = RA_MAX'(id_wb_dest);
        end
        s_mem_d = s_ex_q;
        s_wb_d  = s_mem_q;
        hv_d    = s_wb_q.v && s_wb_q.we;
        hrd_d   = hrd_q;
        hdata_d = hdata_q;
        if (hv_d) begin
            hrd_d   = s_wb_q.rd[RA-1:0];
            hdata_d = wb_data;
        end
    end

    // A load in EXE never reaches this point (it stalls), so only ALU hits use EXMEM.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            fsel_d[i]   = FWD_NONE;
            ex_src_d[i] = ex_src_q[i];
            if (advance) begin
                ex_src_d[i] = id_src_addr[i*RA +: RA];
                if (FWD_EN) begin
                    fsel_d[i] = pick_source(alu_ex[i], hit_mem[i], hit_wb[i]);
                end
            end
        end
    end

    always_comb begin
        ex_operand = ex_operand_raw;
        for (int i = 0; i < NSRC; i++) begin
            case (fsel_q[i])
                FWD_EXMEM: ex_operand[i*ARQ +: ARQ] = exmem_result;
                FWD_MEMWB: ex_operand[i*ARQ +: ARQ] = memwb_result;
                FWD_HOLD: begin
                    if (hv_q && (hrd_q == ex_src_q[i])) begin
                        ex_operand[i*ARQ +: ARQ] = hdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ex_q      <= '0;
            s_mem_q     <= '0;
            s_wb_q      <= '0;
            hv_q        <= 1'b0;
            hrd_q       <= '0;
            hdata_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int i = 0; i < NSRC; i++) begin
                fsel_q[i]   <= FWD_NONE;
                ex_src_q[i] <= '0;
            end
        end else begin
            s_ex_q      <= s_ex_d;
            s_mem_q     <= s_mem_d;
            s_wb_q      <= s_wb_d;
            hv_q        <= hv_d;
            hrd_q       <= hrd_d;
            hdata_q     <= hdata_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            for (int i = 0; i < NSRC; i++) begin
                fsel_q[i]   <= fsel_d[i];
                ex_src_q[i] <= ex_src_d[i];
            end
        end
    end

    assign pc_hold      = hold;
    assign ifid_hold    = hold;
    assign idexe_bubble = hold;
    assign ifid_flush   = branch_taken;
    assign idexe_flush  = branch_taken;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
